// File: rtl/bitfusion_column_ctrl_pkg.sv
// Shared types and lookup constants for the BitFusion column controller.
// Bitwidth codes: 00=2b, 01=4b, 10=8b, 11=reserved (decoded as 8b).
package bitfusion_column_ctrl_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_W,
    ST_STREAM,
    ST_DRAIN,
    ST_FIN
  } col_state_e;

  typedef enum logic [1:0] {
    BW_2B   = 2'b00,
    BW_4B   = 2'b01,
    BW_8B   = 2'b10,
    BW_RSVD = 2'b11
  } bw_code_e;

  // Fusion control word per bitwidth code; the reserved slot carries the 8b pattern.
  localparam logic [31:0] SIG_LUT [4] = '{
    32'h5555_5555,
    32'h3333_3333,
    32'h0F0F_0F0F,
    32'h0F0F_0F0F
  };

  localparam logic [7:0] SUM_SIG_LUT [4] = '{
    8'h01,
    8'h03,
    8'h0F,
    8'h0F
  };

  function automatic logic [1:0] lut_index(input logic [1:0] bw);
    return (bw == 2'(BW_RSVD)) ? 2'(BW_8B) : bw;
  endfunction

endpackage

// File: rtl/bitfusion_column_ctrl_col_sig_decode.sv
// Registered bitwidth -> fusion signal / sum_signal lookup for one column.
// Captures a new value only on load, so the words stay constant for a whole job.
module col_sig_decode
  import bitfusion_column_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [1:0]  bitwidth,
  output logic [31:0] signal,
  output logic [7:0]  sum_signal
);

  always_ff @(posedge clk) begin
    if (reset) begin
      signal     <= '0;
      sum_signal <= '0;
    end else if (load) begin
      signal     <= SIG_LUT[lut_index(bitwidth)];
      sum_signal <= SUM_SIG_LUT[lut_index(bitwidth)];
    end
  end

endmodule

// File: rtl/bitfusion_column_ctrl.sv
// Job sequencer for one BitFusion PE column: weight load, input streaming, pipeline drain.
// Optional perf counters (stall_cnt, job_cnt) are built when COL_CTRL_PERF_CNT_EN is defined.
module bitfusion_column_ctrl
  import bitfusion_column_ctrl_pkg::*;
#(
  parameter int N_PE       = 16,
  parameter int W_LOAD_LAT = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  cfg_bitwidth,
  input  logic [7:0]  cfg_len,
  input  logic        in_valid,
  output logic        in_ready,
  output logic        wbuf_load,
  output logic [1:0]  input_bitwidth,
  output logic [31:0] signal,
  output logic [7:0]  sum_signal,
  output logic        acc_clear,
  output logic        out_valid,
  output logic        busy,
  output logic        done
`ifdef COL_CTRL_PERF_CNT_EN
  ,
  output logic [15:0] stall_cnt,
  output logic [15:0] job_cnt
`endif
);

  localparam int PH_MAX = (N_PE > W_LOAD_LAT) ? N_PE : W_LOAD_LAT;
  localparam int PW     = $clog2(PH_MAX + 1);

  col_state_e      state;
  logic [7:0]      len_cnt;
  logic [PW-1:0]   phase_cnt;
  logic            start_ok;

  assign start_ok = (state == ST_IDLE) && start;

  // Decoded straight from cfg_bitwidth at the accepting edge so the words are valid in LOAD_W.
  col_sig_decode u_sig_decode (
    .clk        (clk),
    .reset      (reset),
    .load       (start_ok),
    .bitwidth   (cfg_bitwidth),
    .signal     (signal),
    .sum_signal (sum_signal)
  );

  // NOTE: every output is assigned together with the state it belongs to, so outputs
  // come straight from flops and line up cycle-for-cycle with the state register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= ST_IDLE;
      len_cnt        <= '0;
      phase_cnt      <= '0;
      input_bitwidth <= '0;
      in_ready       <= 1'b0;
      wbuf_load      <= 1'b0;
      acc_clear      <= 1'b0;
      out_valid      <= 1'b0;
      busy           <= 1'b0;
      done           <= 1'b0;
    end else begin
      wbuf_load <= 1'b0;
      acc_clear <= 1'b0;
      out_valid <= 1'b0;
      done      <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            input_bitwidth <= cfg_bitwidth;
            len_cnt        <= (cfg_len == 8'd0) ? 8'd1 : cfg_len;
            phase_cnt      <= PW'(W_LOAD_LAT - 1);
            wbuf_load      <= 1'b1;
            acc_clear      <= 1'b1;
            busy           <= 1'b1;
            state          <= ST_LOAD_W;
          end
        end
        ST_LOAD_W: begin
          if (phase_cnt == '0) begin
            in_ready <= 1'b1;
            state    <= ST_STREAM;
          end else begin
            phase_cnt <= phase_cnt - PW'(1);
          end
        end
        ST_STREAM: begin
          if (in_valid) begin
            len_cnt <= len_cnt - 8'd1;
            if (len_cnt == 8'd1) begin
              in_ready  <= 1'b0;
              phase_cnt <= PW'(N_PE);
              state     <= ST_DRAIN;
            end
          end
        end
        ST_DRAIN: begin
          if (phase_cnt == '0) begin
            out_valid <= 1'b1;
            done      <= 1'b1;
            state     <= ST_FIN;
          end else begin
            phase_cnt <= phase_cnt - PW'(1);
          end
        end
        ST_FIN: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
        default: begin
          in_ready <= 1'b0;
          busy     <= 1'b0;
          state    <= ST_IDLE;
        end
      endcase
    end
  end

`ifdef COL_CTRL_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      job_cnt   <= '0;
    end else begin
      if (start_ok) begin
        stall_cnt <= '0;
      end else if ((state == ST_STREAM) && !in_valid && (stall_cnt != 16'hFFFF)) begin
        stall_cnt <= stall_cnt + 16'd1;
      end
      if ((state == ST_FIN) && (job_cnt != 16'hFFFF)) begin
        job_cnt <= job_cnt + 16'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_bitfusion_column_ctrl.sv
// Self-checking bench for bitfusion_column_ctrl: table of jobs plus hand-written corner sequences.
// Build with COL_CTRL_PERF_CNT_EN defined to also check the perf counters.
module tb_bitfusion_column_ctrl;

  localparam int N_PE = 16;
  localparam int WLAT = 2;
  localparam int NV   = 6;

  logic        clk = 1'b0;
  logic        reset, start, in_valid;
  logic [1:0]  cfg_bitwidth;
  logic [7:0]  cfg_len;
  logic        in_ready, wbuf_load, acc_clear, out_valid, busy, done;
  logic [1:0]  input_bitwidth;
  logic [31:0] signal;
  logic [7:0]  sum_signal;
`ifdef COL_CTRL_PERF_CNT_EN
  logic [15:0] stall_cnt, job_cnt;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  bitfusion_column_ctrl #(.N_PE(N_PE), .W_LOAD_LAT(WLAT)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .cfg_bitwidth   (cfg_bitwidth),
    .cfg_len        (cfg_len),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .wbuf_load      (wbuf_load),
    .input_bitwidth (input_bitwidth),
    .signal         (signal),
    .sum_signal     (sum_signal),
    .acc_clear      (acc_clear),
    .out_valid      (out_valid),
    .busy           (busy),
    .done           (done)
`ifdef COL_CTRL_PERF_CNT_EN
    ,
    .stall_cnt      (stall_cnt),
    .job_cnt        (job_cnt)
`endif
  );

  typedef struct {
    logic [1:0]  bw;
    logic [7:0]  len;
    int          stall;
    int          exp_done;
    int          exp_beats;
    logic [31:0] exp_sig;
    logic [7:0]  exp_sum;
  } vec_t;

  vec_t vecs [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_outputs(input string name);
    check({name, "_ctl"}, {in_ready, wbuf_load, acc_clear, out_valid, busy, done, input_bitwidth, sum_signal}, 64'd0);
    check({name, "_sig"}, signal, 64'd0);
  endtask

  initial begin
    int cyc, beats, dones, done_cyc, wb_n, wb_cyc, ac_cyc, ir_first, ir_last, stall_left, k;
    logic sig_ok, ov_at_done;
    logic [31:0] sig0;
    logic [7:0]  sum0;

    // Expected done cycle = 1 (start) + WLAT + beats + stalls + N_PE + 1.
    vecs[0] = '{2'b00, 8'd4,   0, 24,  4,   32'h5555_5555, 8'h01};
    vecs[1] = '{2'b01, 8'd3,   0, 23,  3,   32'h3333_3333, 8'h03};
    vecs[2] = '{2'b10, 8'd3,   5, 28,  3,   32'h0F0F_0F0F, 8'h0F};
    vecs[3] = '{2'b11, 8'd0,   0, 21,  1,   32'h0F0F_0F0F, 8'h0F};
    vecs[4] = '{2'b01, 8'd255, 0, 275, 255, 32'h3333_3333, 8'h03};
    vecs[5] = '{2'b00, 8'd1,   0, 21,  1,   32'h5555_5555, 8'h01};

    reset = 1'b1; start = 1'b0; in_valid = 1'b0; cfg_bitwidth = '0; cfg_len = '0;
    step(); step();
    check_idle_outputs("reset");
    reset = 1'b0;
    step();

    for (int i = 0; i < NV; i++) begin
      cfg_bitwidth = vecs[i].bw;
      cfg_len      = vecs[i].len;
      start        = 1'b1;
      in_valid     = 1'b1;
      cyc = 0; beats = 0; dones = 0; done_cyc = -1; wb_n = 0; wb_cyc = -1; ac_cyc = -1;
      ir_first = -1; ir_last = -1; stall_left = vecs[i].stall;
      sig_ok = 1'b1; ov_at_done = 1'b0; sig0 = '0; sum0 = '0;
      while (cyc < vecs[i].exp_done + 3 && cyc < 400) begin
        if (in_ready && in_valid) beats++;
        step();
        cyc++;
        start = 1'b0;
        if (wbuf_load) begin wb_n++; wb_cyc = cyc; end
        if (acc_clear) ac_cyc = cyc;
        if (in_ready) begin
          if (ir_first < 0) ir_first = cyc;
          ir_last = cyc;
        end
        if (done) begin dones++; done_cyc = cyc; ov_at_done = out_valid; end
        if (cyc == 1) begin
          sig0 = signal;
          sum0 = sum_signal;
        end else if (busy && (signal !== sig0 || sum_signal !== sum0)) begin
          sig_ok = 1'b0;
        end
        if (in_ready && beats >= 1 && stall_left > 0) begin
          in_valid = 1'b0;
          stall_left--;
        end else begin
          in_valid = 1'b1;
        end
      end
      check($sformatf("v%0d_done_cycle", i), 64'(done_cyc), 64'(vecs[i].exp_done));
      check($sformatf("v%0d_done_count", i), 64'(dones), 64'd1);
      check($sformatf("v%0d_out_valid", i), 64'(ov_at_done), 64'd1);
      check($sformatf("v%0d_beats", i), 64'(beats), 64'(vecs[i].exp_beats));
      check($sformatf("v%0d_wbuf_load", i), {32'(wb_n), 32'(wb_cyc)}, {32'd1, 32'd1});
      check($sformatf("v%0d_acc_clear", i), 64'(ac_cyc), 64'd1);
      check($sformatf("v%0d_ready_first", i), 64'(ir_first), 64'(1 + WLAT));
      check($sformatf("v%0d_ready_last", i), 64'(ir_last), 64'(vecs[i].exp_done - N_PE - 2));
      check($sformatf("v%0d_signal", i), sig0, vecs[i].exp_sig);
      check($sformatf("v%0d_sum_signal", i), sum0, vecs[i].exp_sum);
      check($sformatf("v%0d_sig_stable", i), 64'(sig_ok), 64'd1);
      check($sformatf("v%0d_in_bw", i), input_bitwidth, vecs[i].bw);
      check($sformatf("v%0d_idle_after", i), {busy, in_ready}, 64'd0);
`ifdef COL_CTRL_PERF_CNT_EN
      check($sformatf("v%0d_stall_cnt", i), stall_cnt, 64'(vecs[i].stall));
      check($sformatf("v%0d_job_cnt", i), job_cnt, 64'(i + 1));
`endif
    end

    // start pulsed during DRAIN is dropped, not queued
    cfg_bitwidth = 2'b01; cfg_len = 8'd2; in_valid = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (k = 0; k < 20 && !in_ready; k++) step();
    check("drain_reach_stream", 64'(in_ready), 64'd1);
    for (k = 0; k < 20 && in_ready; k++) step();
    check("drain_in_drain", {busy, in_ready, done}, {61'd0, 3'b100});
    start = 1'b1;
    step();
    start = 1'b0;
    dones = 0;
    for (k = 0; k < 40; k++) begin
      if (done) dones++;
      step();
    end
    check("drain_done_count", 64'(dones), 64'd1);
    check("drain_no_queue", {busy, wbuf_load}, 64'd0);
    start = 1'b1;
    step();
    start = 1'b0;
    check("idle_start_taken", {busy, wbuf_load, acc_clear}, 64'h7);
    for (k = 0; k < 60 && !done; k++) step();
    check("idle_start_done", 64'(done), 64'd1);
    step(); step();

    // reset on the 2nd STREAM beat aborts at that edge with no done pulse
    cfg_bitwidth = 2'b10; cfg_len = 8'd4; in_valid = 1'b1; start = 1'b1;
    step();
    start = 1'b0;
    for (k = 0; k < 20 && !in_ready; k++) step();
    check("abort_reach_stream", 64'(in_ready), 64'd1);
    step();
    check("abort_second_beat", 64'(in_ready), 64'd1);
    reset = 1'b1;
    step();
    check_idle_outputs("abort");
`ifdef COL_CTRL_PERF_CNT_EN
    check("abort_perf", {stall_cnt, job_cnt}, 64'd0);
`endif
    reset = 1'b0;
    dones = 0;
    for (k = 0; k < 30; k++) begin
      step();
      if (done || busy) dones++;
    end
    check("abort_stays_idle", 64'(dones), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bitfusion_column_ctrl.md
BITFUSION_COLUMN_CTRL -- requirements
Module: bitfusion_column_ctrl

Interface
REQ-001 SHALL have parameter N_PE, default 16, number of PE stages in the column chain.
REQ-002 SHALL have parameter W_LOAD_LAT, default 2, weight path latency in cycles (weight buffer plus weight mux register).
REQ-003 SHALL have one clock and one reset: clk in 1, the single clock; reset in 1, synchronous, active-high.
REQ-004 SHALL have these ports, one per entry, as name direction width meaning:
- start in 1: begin one job; sampled only in IDLE.
- cfg_bitwidth in 2: operand bitwidth code for the job.
- cfg_len in 8: number of input vectors in the job; 0 is treated as 1.
- in_valid in 1: input buffer has a vector.
- in_ready out 1: controller accepts a vector this cycle.
- wbuf_load out 1: one-cycle strobe that loads the weight buffers.
- input_bitwidth out 2: latched cfg_bitwidth, driven to the column.
- signal out 32: fusion control word for the column.
- sum_signal out 8: shift/sum control word for the column.
- acc_clear out 1: one-cycle clear of the column accumulator.
- out_valid out 1: total_output is final this cycle.
- busy out 1: high in every state except IDLE.
- done out 1: one-cycle pulse at job end.

Function
REQ-005 SHALL implement the FSM IDLE -> LOAD_W -> STREAM -> DRAIN -> FIN -> IDLE.
REQ-006 IDLE: on start=1, SHALL latch cfg_bitwidth and max(cfg_len,1), pulse wbuf_load and acc_clear for 1 cycle, and go to LOAD_W.
REQ-007 LOAD_W SHALL last exactly W_LOAD_LAT cycles, counted by a down-counter, then go to STREAM.
REQ-008 STREAM: in_ready SHALL be 1; a beat is accepted when in_valid=1; the remaining count SHALL decrement per accepted beat; the accepted beat that brings the count to 0 SHALL move the FSM to DRAIN.
REQ-009 When in_valid=0 in STREAM, the FSM SHALL stall without a timeout and without changing the count.
REQ-010 DRAIN SHALL last N_PE+1 cycles (N_PE PE register stages plus 1 accumulator stage) after the last accepted beat; in_ready SHALL be 0.
REQ-011 FIN SHALL last 1 cycle with out_valid=1 and done=1, then return to IDLE.
REQ-012 signal and sum_signal SHALL be a registered lookup of the latched bitwidth; they SHALL be valid from LOAD_W onward and held constant until the next IDLE->LOAD_W transition.
REQ-013 start asserted while busy=1 SHALL be ignored, with no queuing.
REQ-014 The job length counter SHALL be 8-bit; cfg_len=255 SHALL take exactly 255 accepted beats with no wrap-around.

Reset
REQ-015 reset SHALL be synchronous active-high; it forces state IDLE, all counters to 0, in_ready=0, wbuf_load=0, acc_clear=0, out_valid=0, busy=0, done=0, input_bitwidth=0, signal=0, sum_signal=0.
REQ-016 reset asserted mid-job SHALL abort the job within the same clock edge, with no done pulse.

Configuration
REQ-017 With COL_CTRL_PERF_CNT_EN defined, the block SHALL add outputs stall_cnt[15:0], the number of STREAM cycles with in_valid=0, and job_cnt[15:0], the number of completed jobs; both saturate, both clear on reset, and stall_cnt also clears on each job start.
REQ-018 Without COL_CTRL_PERF_CNT_EN, the block SHALL have neither those ports nor those counters, and all other behaviour SHALL be identical.

Structure
REQ-019 A shared package SHALL hold the state enum, the bitwidth codes (00=2b, 01=4b, 10=8b, 11=reserved, which maps to 8b), and the lookup constants SIG_LUT and SUM_SIG_LUT.
REQ-020 The block SHALL have one sub-module, col_sig_decode: a registered bitwidth-to-signal/sum_signal lookup.

Verification
REQ-021 Reset, then start, cfg_len=4, in_valid held 1 -> wbuf_load and acc_clear pulse at cycle 1; in_ready is high during cycles 3-6; out_valid and done pulse at cycle 24 (1+2+4+17).
REQ-022 cfg_len=3 with in_valid low for 5 cycles after the first beat -> done is delayed by exactly 5 cycles versus the no-stall case; with COL_CTRL_PERF_CNT_EN, stall_cnt=5.
REQ-023 cfg_len=0 -> behaves as cfg_len=1; exactly one beat is accepted.
REQ-024 start pulsed during DRAIN -> ignored; exactly one done pulse; the next start is accepted only in IDLE.
REQ-025 reset asserted at the 2nd STREAM beat -> the next cycle is IDLE, all outputs at reset values, no done pulse.
REQ-026 cfg_bitwidth=11 -> signal and sum_signal equal the 8b lookup entries; they are stable from LOAD_W through FIN.
